pipeline_muldiv_unit: RTL and testbench
=======================================

# pipeline_muldiv_unit

Iterative multiply/divide sequencer with architectural HI/LO registers for the 5-stage pipeline. It handles MULT, MULTU, DIV, DIVU, MTHI, MTLO and MFHI/MFLO. An EX-stage instruction launches an operation, and the unit then runs a multi-cycle state machine while other instructions keep flowing. It requests a pipeline stall only when a later instruction touches HI/LO, or launches a new operation, before the current one retires.

## Interface
Parameters:
- `ITERATIONS`, default 32: shift-add / restoring-divide iteration count; equals operand width.

Ports:
- `clk`  in  1  pipeline clock, rising edge.
- `reset`  in  1  asynchronous, active-low; low forces the reset state immediately.
- `start`  in  1  EX holds a valid mul/div instruction this cycle.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `operand_a`  in  32  rs value (multiplicand/dividend).
- `operand_b`  in  32  rt value (multiplier/divisor).
- `write_hi`  in  1  MTHI in EX.
- `write_lo`  in  1  MTLO in EX.
- `write_data`  in  32  rs value for MTHI/MTLO.
- `hilo_read`  in  1  MFHI/MFLO in EX.
- `flush`  in  1  synchronous abort of the in-flight operation.
- `busy`  out  1  state is not IDLE.
- `stall_request`  out  1  combinational: `busy & (start | write_hi | write_lo | hilo_read)`.
- `done`  out  1  one-cycle pulse when HI/LO take a mul/div result.
- `div_by_zero`  out  1  qualifies `done`: divide with `operand_b` = 0.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
States:
- **IDLE**
  - `start` latches op and operands, then goes to PREP.
  - Otherwise `write_hi`/`write_lo` update HI/LO at the edge.
  - `start` has priority over a same-cycle write; the write is dropped.
- **PREP**
  - Signed ops take absolute values and record the result signs.
  - Divide with zero divisor goes straight to FIX; all other ops go to ITER with count = 0.
- **ITER**
  - Multiply: one shift-add step per cycle on a 64-bit product.
  - Divide: one restoring step per cycle (remainder/quotient shift).
  - count == ITERATIONS−1 goes to FIX.
- **FIX**
  - Applies sign correction and writes HI/LO.
  - Asserts `done` in the following cycle and returns to IDLE.

Results:
- Multiply: {HI, LO} = full 64-bit product; signed for MULT, unsigned for MULTU.
- Divide: LO = quotient, truncated toward zero; HI = remainder, which takes the dividend's sign.
- 0x80000000 / −1 gives LO = 0x80000000, HI = 0 (wrap, no trap).
- Divide by zero: HI = operand_a, LO = 0xFFFFFFFF, `div_by_zero` = 1 with `done`.

Conditions and events:
- `flush` while `busy`: next edge goes to IDLE. HI/LO are unchanged and there is no `done`.
- `flush` in IDLE: same-cycle `start` and writes are ignored.
- `start` while `busy`: not accepted; `stall_request` holds EX until IDLE.
- `reset` low at any time, including mid-operation: state goes to IDLE with the reset values below.

Reset values: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, `div_by_zero` = 0; iteration counter and internal product/remainder registers are cleared.

## Timing
- `start` is accepted at edge T0. Timeline:
  - PREP: T0–T1.
  - ITER: T1–T33.
  - FIX: T33–T34.
- HI/LO update at edge T34; `done` is high for cycle T34–T35; `busy` falls at T34.
- Total latency from acceptance is 34 cycles, fixed for every operand value; there is no early termination.
- Divide by zero: HI/LO are written at T2, with `done` and `div_by_zero` high for cycle T2–T3.
- A new `start` presented in the cycle where `done` is high is accepted.
- MTHI/MTLO in IDLE: `hi`/`lo` are visible the cycle after the edge.
- `stall_request` is purely combinational from the current state and inputs, with no registered delay.

## Configuration
- `PIPELINE_MULDIV_DIV_EN` defined:
  - Full divide support as above.
- `PIPELINE_MULDIV_DIV_EN` undefined:
  - Divider datapath is removed.
  - DIV/DIVU `start` is accepted but treated as a no-op: the state stays IDLE and HI/LO are unchanged.
  - `done` pulses in the next cycle with `div_by_zero` = 0.
  - MULT/MULTU timing is unaffected.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 34 cycles HI = 0xFFFFFFFE, LO = 0x00000001, `done` pulse exactly one cycle.
- MULT −3 × 5 → HI = 0xFFFFFFFF, LO = 0xFFFFFFF1; then DIV −7 / 2 → LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIVU 100 / 0 → `done` and `div_by_zero` at T2, HI = 0x00000064, LO = 0xFFFFFFFF.
- MTHI 0x1234 in IDLE, then MULTU 2 × 3 with `hilo_read` asserted at T5 → `stall_request` high T5–T33, low when `done`; HI = 0, LO = 6.
- HI/LO preloaded 0xAAAA/0x5555, MULTU started, `flush` at T10 → IDLE at T11, no `done`, HI/LO still 0xAAAA/0x5555.
- `reset` low at T20 mid-DIV → `busy`, `hi`, `lo` = 0 immediately; a new MULTU 7 × 7 after release → LO = 49 at 34 cycles.

Source files
------------

// File: rtl/pipeline_muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with architectural HI/LO registers.
// Define PIPELINE_MULDIV_DIV_EN to build the restoring divider; otherwise divides retire as no-ops.
`timescale 1ns/1ps
module pipeline_muldiv_unit #(
  parameter int ITERATIONS = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  input  logic        write_hi,
  input  logic        write_lo,
  input  logic [31:0] write_data,
  input  logic        hilo_read,
  input  logic        flush,
  output logic        busy,
  output logic        stall_request,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CW = $clog2(ITERATIONS) + 1;
  localparam logic [CW-1:0] LAST = CW'(ITERATIONS - 1);

  typedef enum logic [1:0] {S_IDLE, S_PREP, S_ITER, S_FIX} state_t;
  state_t r_state, w_state_nxt;

  logic [CW-1:0] r_count;
  logic          r_signed;
`ifdef PIPELINE_MULDIV_DIV_EN
  logic          r_is_div;
  logic          r_neg_r;
  logic [32:0]   w_rem_sh;
  logic [32:0]   w_diff;
`endif
  logic [31:0]   r_a, r_b, r_m;
  logic [63:0]   r_acc, w_step;
  logic [32:0]   w_sum;
  logic          r_neg_q, r_dbz;
  logic          r_done, r_dbz_out;
  logic [31:0]   r_hi, r_lo;
  logic [31:0]   w_abs_a, w_abs_b;
  logic          w_div_zero, w_done_nxt, w_dbz_nxt;

  function automatic logic [31:0] f_mag(input logic [31:0] v, input logic sgn);
    return (sgn && v[31]) ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [31:0] f_neg32(input logic [31:0] v, input logic neg);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [63:0] f_neg64(input logic [63:0] v, input logic neg);
    return neg ? (~v + 64'd1) : v;
  endfunction

  assign w_abs_a = f_mag(r_a, r_signed);
  assign w_abs_b = f_mag(r_b, r_signed);

`ifdef PIPELINE_MULDIV_DIV_EN
  assign w_div_zero = r_is_div && (r_b == 32'd0);
`else
  assign w_div_zero = 1'b0;
`endif

  // One iteration: shift-add for multiply, restoring subtract for divide
  always_comb begin
    w_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_m} : 33'd0);
    w_step = {w_sum, r_acc[31:1]};
`ifdef PIPELINE_MULDIV_DIV_EN
    w_rem_sh = {r_acc[63:32], r_acc[31]};
    w_diff   = w_rem_sh - {1'b0, r_m};
    if (r_is_div) begin
      if (!w_diff[32]) w_step = {w_diff[31:0], r_acc[30:0], 1'b1};
      else             w_step = {w_rem_sh[31:0], r_acc[30:0], 1'b0};
    end
`endif
  end

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_dbz_nxt   = 1'b0;
    if (flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
`ifdef PIPELINE_MULDIV_DIV_EN
            w_state_nxt = S_PREP;
`else
            if (op[1]) w_done_nxt = 1'b1;
            else       w_state_nxt = S_PREP;
`endif
          end
        end
        S_PREP:  w_state_nxt = w_div_zero ? S_FIX : S_ITER;
        S_ITER:  if (r_count == LAST) w_state_nxt = S_FIX;
        S_FIX: begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
          w_dbz_nxt   = r_dbz;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_done    <= 1'b0;
      r_dbz_out <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_done    <= w_done_nxt;
      r_dbz_out <= w_dbz_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count  <= '0;
      r_signed <= 1'b0;
`ifdef PIPELINE_MULDIV_DIV_EN
      r_is_div <= 1'b0;
      r_neg_r  <= 1'b0;
`endif
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_acc    <= '0;
      r_neg_q  <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!flush) begin
            if (start) begin
              r_signed <= ~op[0];
`ifdef PIPELINE_MULDIV_DIV_EN
              r_is_div <= op[1];
`endif
              r_a      <= operand_a;
              r_b      <= operand_b;
            end else begin
              if (write_hi) r_hi <= write_data;
              if (write_lo) r_lo <= write_data;
            end
          end
        end
        S_PREP: begin
          r_count <= '0;
          r_dbz   <= w_div_zero;
          r_neg_q <= r_signed && (r_a[31] ^ r_b[31]);
`ifdef PIPELINE_MULDIV_DIV_EN
          r_neg_r <= r_signed && r_a[31];
          if (r_is_div) begin
            r_m   <= w_abs_b;
            r_acc <= {32'd0, w_abs_a};
          end else begin
            r_m   <= w_abs_a;
            r_acc <= {32'd0, w_abs_b};
          end
`else
          r_m   <= w_abs_a;
          r_acc <= {32'd0, w_abs_b};
`endif
        end
        S_ITER: begin
          r_count <= r_count + CW'(1);
          r_acc   <= w_step;
        end
        S_FIX: begin
          // Sign correction and architectural write-back
          if (!flush) begin
`ifdef PIPELINE_MULDIV_DIV_EN
            if (r_dbz) begin
              r_hi <= r_a;
              r_lo <= 32'hFFFF_FFFF;
            end else if (r_is_div) begin
              r_lo <= f_neg32(r_acc[31:0], r_neg_q);
              r_hi <= f_neg32(r_acc[63:32], r_neg_r);
            end else begin
              {r_hi, r_lo} <= f_neg64(r_acc, r_neg_q);
            end
`else
            {r_hi, r_lo} <= f_neg64(r_acc, r_neg_q);
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy          = (r_state != S_IDLE);
  assign stall_request = busy & (start | write_hi | write_lo | hilo_read);
  assign done          = r_done;
  assign div_by_zero   = r_dbz_out;
  assign hi            = r_hi;
  assign lo            = r_lo;

endmodule

// File: tb/tb_pipeline_muldiv_unit.sv
// Directed table-driven bench for pipeline_muldiv_unit; divide expectations follow PIPELINE_MULDIV_DIV_EN.
`timescale 1ns/1ps
module tb_pipeline_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        write_hi = 1'b0;
  logic        write_lo = 1'b0;
  logic [31:0] write_data = '0;
  logic        hilo_read = 1'b0;
  logic        flush = 1'b0;
  logic        busy, stall_request, done, div_by_zero;
  logic [31:0] hi, lo;

`ifdef PIPELINE_MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  pipeline_muldiv_unit #(.ITERATIONS(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b),
    .write_hi(write_hi), .write_lo(write_lo), .write_data(write_data),
    .hilo_read(hilo_read), .flush(flush),
    .busy(busy), .stall_request(stall_request), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t        vecs[12];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi, m_lo;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic wait_done(output int lat, output logic busy1);
    lat   = 0;
    busy1 = 1'b0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) busy1 = busy;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic busy1);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(lat, busy1);
  endtask

  task automatic wr(input logic whi, input logic wlo, input logic [31:0] d);
    write_hi = whi; write_lo = wlo; write_data = d;
    @(posedge clk); #1;
    write_hi = 1'b0; write_lo = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, exp_lat, bad, seen;
    logic busy1, is_div, runs;

    vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
    vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[6]  = '{2'b00, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0};
    vecs[7]  = '{2'b11, 32'hFFFF_FFFF, 32'h0000_000A, 32'h0000_0005, 32'h1999_9999, 1'b0};
    vecs[8]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[9]  = '{2'b01, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[10] = '{2'b10, 32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF, 1'b1};
    vecs[11] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_hi", hi, 0);
    chk("reset_lo", lo, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dbz", div_by_zero, 0);
    reset = 1'b1;
    m_hi = 32'h0; m_lo = 32'h0;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      is_div = vecs[i].op[1];
      runs   = !is_div || DIV_EN;
      if (is_div && !DIV_EN)              exp_lat = 0;
      else if (is_div && vecs[i].b == 0)  exp_lat = 2;
      else                                exp_lat = 34;
      if (runs) begin
        m_hi = vecs[i].hi;
        m_lo = vecs[i].lo;
      end
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, busy1);
      chk($sformatf("v%0d_latency", i), lat, exp_lat);
      chk($sformatf("v%0d_busy", i), busy1, exp_lat > 1);
      chk($sformatf("v%0d_dbz", i), div_by_zero, runs ? vecs[i].dbz : 1'b0);
      chk($sformatf("v%0d_hi", i), hi, m_hi);
      chk($sformatf("v%0d_lo", i), lo, m_lo);
      @(posedge clk); #1;
      chk($sformatf("v%0d_done_pulse", i), done, 0);
    end

    // Back-to-back: second start presented in the done cycle
    run_op(2'b01, 32'd3, 32'd4, lat, busy1);
    chk("b2b_first_lo", lo, 32'd12);
    run_op(2'b01, 32'd5, 32'd6, lat, busy1);
    chk("b2b_second_latency", lat, 34);
    chk("b2b_second_lo", lo, 32'd30);
    chk("b2b_second_hi", hi, 32'd0);
    @(posedge clk); #1;

    // start wins over same-cycle MTHI/MTLO
    start = 1'b1; op = 2'b01; operand_a = 32'd1; operand_b = 32'd1;
    write_hi = 1'b1; write_lo = 1'b1; write_data = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0; write_hi = 1'b0; write_lo = 1'b0;
    wait_done(lat, busy1);
    chk("start_prio_hi", hi, 32'd0);
    chk("start_prio_lo", lo, 32'd1);
    @(posedge clk); #1;

    // MTHI then MULTU with MFHI arriving at T5
    wr(1'b1, 1'b0, 32'h0000_1234);
    chk("mthi_hi", hi, 32'h0000_1234);
    chk("mthi_lo", lo, 32'd1);
    start = 1'b1; op = 2'b01; operand_a = 32'd2; operand_b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    hilo_read = 1'b1;
    bad = 0;
    for (int k = 5; k <= 34; k++) begin
      if (k > 5) @(posedge clk);
      #1;
      if (stall_request !== (k < 34) || done !== (k == 34)) bad++;
      if (k < 34) #0;
    end
    chk("stall_window", bad, 0);
    hilo_read = 1'b0;
    chk("stall_mul_hi", hi, 32'd0);
    chk("stall_mul_lo", lo, 32'd6);
    @(posedge clk); #1;

    // Flush mid-multiply
    wr(1'b1, 1'b0, 32'h0000_AAAA);
    wr(1'b0, 1'b1, 32'h0000_5555);
    start = 1'b1; op = 2'b01; operand_a = 32'd9; operand_b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("flush_busy_before", busy, 1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy_after", busy, 0);
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    chk("flush_no_done", seen, 0);
    chk("flush_hi", hi, 32'h0000_AAAA);
    chk("flush_lo", lo, 32'h0000_5555);

    // Flush in IDLE suppresses start and writes
    flush = 1'b1; start = 1'b1; op = 2'b01; write_hi = 1'b1; write_data = 32'h0000_0001;
    @(posedge clk); #1;
    flush = 1'b0; start = 1'b0; write_hi = 1'b0;
    chk("idle_flush_busy", busy, 0);
    chk("idle_flush_hi", hi, 32'h0000_AAAA);
    @(posedge clk); #1;
    chk("idle_flush_done", done, 0);

    // Asynchronous reset mid-operation
    start = 1'b1; op = DIV_EN ? 2'b10 : 2'b01; operand_a = 32'd1000; operand_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (20) @(posedge clk);
    #3;
    chk("pre_reset_busy", busy, 1);
    reset = 1'b0;
    #1;
    chk("async_reset_busy", busy, 0);
    chk("async_reset_hi", hi, 32'd0);
    chk("async_reset_lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_op(2'b01, 32'd7, 32'd7, lat, busy1);
    chk("post_reset_latency", lat, 34);
    chk("post_reset_lo", lo, 32'd49);
    chk("post_reset_hi", hi, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
